adder_share_arbiter: RTL and testbench

- Sequences one shared, external, combinational WIDTH-bit adder (carry-select or ripple, instantiated by the parent) between NUM_REQ requesters.
- Round-robin grant; operands are held stable on the adder for SETTLE_CYCLES, then sum and carry-out are captured and returned on a single response channel tagged with the requester id.
- Sits between the ALU-issue logic and the adder instance; the adder itself is unchanged.

---
 rtl/adder_share_pkg.sv | 41 ++++
 rtl/rr_picker.sv | 33 +++
 rtl/adder_share_arbiter.sv | 168 ++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter.
//   state_t  : arbiter FSM states (IDLE, SETTLE, RESP)
//   ST_W     : state encoding width
//   DEF_WIDTH: default operand/sum width
//   MAX_REQ  : largest requester count rr_pick supports
//   rr_pick  : round-robin pick of the first valid index at or after ptr
package adder_share_pkg;

  localparam int unsigned ST_W      = 2;
  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned MAX_REQ   = 8;

  typedef enum logic [ST_W-1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Returns the first index with valid set, scanning from ptr and wrapping
  // modulo n. Returns 0 when nothing is valid (the caller gates on |valid).
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n && !found) begin
        idx = 3'((32'(ptr) + k) % n);
        if (valid[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   i_valid : per-requester valid bits
//   i_ptr   : current priority pointer (index served first)
//   o_grant : one-hot grant (zero when nothing is valid)
//   o_idx   : index of the granted requester
//   o_any   : at least one requester valid
module rr_picker
  import adder_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [MAX_REQ-1:0] w_valid8;
  logic [2:0]         w_idx3;

  always_comb begin
    w_valid8                = '0;
    w_valid8[NUM_REQ-1:0]   = i_valid;
  end

  assign w_idx3  = rr_pick(w_valid8, 3'(i_ptr), NUM_REQ);
  assign o_idx   = IDX_W'(w_idx3);
  assign o_any   = |i_valid;
  assign o_grant = o_any ? (NUM_REQ'(1) << w_idx3) : '0;

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one external combinational adder between NUM_REQ requesters.
// A round-robin winner's operands are registered onto the adder, held for
// SETTLE_CYCLES, then sum/carry are captured and returned tagged with the
// requester id on a valid/ready response channel.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : per-requester request handshake
//   req_a/req_b/req_cin        : packed per-requester operands
//   add_a/add_b/add_cin        : registered operands to the shared adder
//   add_sum/add_cout           : adder result
//   rsp_valid/rsp_ready        : response handshake
//   rsp_id/rsp_sum/rsp_cout    : served requester and captured result
//   rsp_err                    : adder self-check mismatch
//   busy                       : FSM not in IDLE
// Optional feature macro: ADDER_SELFCHECK_EN (compare the adder against a
// behavioural sum at capture; rsp_err is tied low when undefined).
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned ID_W          = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_err,
  output logic                     busy
);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_id;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic               r_add_cin;
  logic               r_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_cin;
  logic               w_err;
  logic [ID_W-1:0]    w_ptr_next;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_picker (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // One-hot operand mux driven by the picker's grant.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a   = req_a[i*WIDTH +: WIDTH];
        w_b   = req_b[i*WIDTH +: WIDTH];
        w_cin = req_cin[i];
      end
    end
  end

  assign w_ptr_next = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

`ifdef ADDER_SELFCHECK_EN
  logic [WIDTH:0] w_ref;
  assign w_ref = {1'b0, r_add_a} + {1'b0, r_add_b} + {{WIDTH{1'b0}}, r_add_cin};
  assign w_err = (w_ref != {add_cout, add_sum});

  always_ff @(posedge clk) begin
    if (rst_n && r_state == SETTLE && r_cnt == '0) begin
      assert (!w_err)
        else $error("adder self-check mismatch: got %h, ref %h", {add_cout, add_sum}, w_ref);
    end
  end
`else
  assign w_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_id      <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
      r_valid   <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_add_a   <= w_a;
            r_add_b   <= w_b;
            r_add_cin <= w_cin;
            r_id      <= w_idx;
            r_cnt     <= 4'(SETTLE_CYCLES - 1);
            r_ptr     <= w_ptr_next;
            r_state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_sum   <= add_sum;
            r_cout  <= add_cout;
            r_err   <= w_err;
            r_valid <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;
  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_err   = r_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter (NUM_REQ=4, WIDTH=64, SETTLE=3).
// Stimulus pushes hand-computed expected responses; a monitor pops and
// compares each accepted response.
module tb_adder_share_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned SC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR-1:0] req_cin;
  logic [W-1:0]  add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [W-1:0]  rsp_sum;
  logic          rsp_cout, rsp_err, busy;

  always #5 clk = ~clk;

  adder_share_arbiter #(
    .NUM_REQ       (NR),
    .WIDTH         (W),
    .SETTLE_CYCLES (SC),
    .ID_W          (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // Shared adder model; the 0xF + 0xF case is deliberately off by one so the
  // self-check path has something to catch.
  logic [W:0] tb_full;
  always_comb begin
    tb_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    if (add_a == 64'hF && add_b == 64'hF) tb_full = tb_full + 1'b1;
  end
  assign add_sum  = tb_full[W-1:0];
  assign add_cout = tb_full[W];

`ifdef ADDER_SELFCHECK_EN
  localparam logic SELF_ERR = 1'b1;
`else
  localparam logic SELF_ERR = 1'b0;
`endif

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a response transfers at the posedge following a negedge where
  // rsp_valid && rsp_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", {63'd0, rsp_id}, 65'h1_FFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("rsp_id",   {63'd0, rsp_id},  {63'd0, e.id});
          check("rsp_sum",  {1'b0, rsp_sum},  {1'b0, e.sum});
          check("rsp_cout", {64'd0, rsp_cout}, {64'd0, e.cout});
          check("rsp_err",  {64'd0, rsp_err},  {64'd0, e.err});
        end
      end
    end
  end

  task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] es, input logic ec,
                       input logic ee, input bit push);
    int t;
    if (push) sb.push_back('{2'(idx), es, ec, ee});
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_cin[idx]      = cin;
    req_valid[idx]    = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[idx] && t < 100);
    check("accept", {64'd0, req_ready[idx]}, 65'd1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", {64'd0, busy}, 65'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int   cyc;
  int   t;
  int   exp_g [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_add_a",     {1'b0, add_a},     65'd0);
    check("rst_rsp_valid", {64'd0, rsp_valid}, 65'd0);
    check("rst_rsp_sum",   {1'b0, rsp_sum},   65'd0);
    check("rst_busy",      {64'd0, busy},     65'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester 0: 1+1+1, latency check.
    sb.push_back('{2'd0, 64'd3, 1'b0, 1'b0});
    req_a[0 +: W] = 64'd1;
    req_b[0 +: W] = 64'd1;
    req_cin[0]    = 1'b1;
    req_valid[0]  = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[0] && t < 50);
    check("t1_ready", {61'd0, req_ready}, 65'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t1_latency", 65'(cyc), 65'(SC + 1));
    wait_idle();

    // Requester 2: all-ones + 1 wraps to 0 with carry.
    issue(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Reset while in SETTLE: request dropped, outputs cleared at once.
    issue(0, 64'd5, 64'd5, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_add_a",   {1'b0, add_a},      65'd0);
    check("mid_rst_add_cin", {64'd0, add_cin},   65'd0);
    check("mid_rst_busy",    {64'd0, busy},      65'd0);
    check("mid_rst_valid",   {64'd0, rsp_valid}, 65'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_rst_no_rsp", {64'd0, rsp_valid}, 65'd0);

    // All four continuously valid: strict rotation from index 0.
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = 64'h0123_4567_89AB_CDEF;
      req_b[i*W +: W] = 64'hFEDC_BA98_7654_3210;
      req_cin[i]      = 1'b0;
    end
    for (int g = 0; g < 5; g++)
      sb.push_back('{2'(exp_g[g]), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0});
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (req_ready == '0 && t < 50);
      check("rr_grant", {61'd0, req_ready}, 65'(4'b0001 << exp_g[g]));
      @(posedge clk); #1;
      if (g == 4) req_valid = '0;
    end
    wait_idle();

    // Back-pressure: requesters 1 and 3 pending, response stalled.
    rsp_ready = 1'b0;
    sb.push_back('{2'd1, 64'd1, 1'b1, 1'b0});
    sb.push_back('{2'd3, 64'h2345, 1'b0, 1'b0});
    req_a[1*W +: W] = 64'h8000_0000_0000_0000;
    req_b[1*W +: W] = 64'h8000_0000_0000_0000;
    req_cin[1]      = 1'b1;
    req_a[3*W +: W] = 64'h1234;
    req_b[3*W +: W] = 64'h1111;
    req_cin[3]      = 1'b0;
    req_valid       = 4'b1010;
    t = 0;
    do begin @(negedge clk); t++; end while (req_ready == '0 && t < 50);
    check("bp_grant", {61'd0, req_ready}, 65'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, busy, req_ready, rsp_id, rsp_cout, rsp_sum[55:0]},
            {1'b1, 1'b1, 4'b0000, 2'd1, 1'b1, 56'd1});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_busy",  {64'd0, busy},      65'd0);
    check("bp_idle_valid", {64'd0, rsp_valid}, 65'd0);
    check("bp_next_grant", {61'd0, req_ready}, 65'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_idle();

    // Faulty adder case: sum is 0x1F; rsp_err set only with the self-check.
    issue(0, 64'hF, 64'hF, 1'b0, 64'h1F, 1'b0, SELF_ERR, 1'b1);
    wait_idle();

    check("sb_empty", 65'(sb.size()), 65'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
